// File: rtl/bird_control.sv
// bird_control: per-bird flight sequencer. Drives the bird datapath's 4-bit
// control code each cycle: draw, wait for the frame tick, clear, step, settle,
// redraw. Handles edge bounce, shot latching and the shot/escape endings.
// Optional build macro: BIRD_RANDOM_TURN_EN adds an LFSR that occasionally
// reverses the horizontal direction on a flight step.
module bird_control #(
  parameter int TICK_DIV      = 833333,
  parameter int ESCAPE_FRAMES = 600,
  parameter int X_MAX         = 157,
  parameter int Y_MAX         = 117
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic       hit,
  input  logic       enable,
  input  logic       flying,
  input  logic [7:0] Xpos,
  input  logic [6:0] Ypos,
  output logic [3:0] control,
  output logic       bird_active,
  output logic       bird_shot,
  output logic       bird_escaped
);

  localparam logic [3:0] C_HOLD       = 4'b0000;
  localparam logic [3:0] C_CLEAR      = 4'b0001;
  localparam logic [3:0] C_UP_LEFT    = 4'b0010;
  localparam logic [3:0] C_UP_RIGHT   = 4'b0011;
  localparam logic [3:0] C_PREHOLD    = 4'b0100;
  localparam logic [3:0] C_DRAW       = 4'b0101;
  localparam logic [3:0] C_DOWN_RIGHT = 4'b0110;
  localparam logic [3:0] C_DOWN_LEFT  = 4'b0111;
  localparam logic [3:0] C_SHOT       = 4'b1000;
  localparam logic [3:0] C_ESCAPE     = 4'b1001;
  localparam logic [3:0] C_NEW        = 4'b1010;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEW, S_DRAW, S_WAIT, S_CLEAR, S_STEP, S_SETTLE, S_DONE
  } state_t;

  typedef enum logic [1:0] {M_FLY, M_SHOT, M_ESC} mode_t;

  state_t        r_state, w_state_nxt;
  mode_t         r_mode;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [15:0]   r_frames;
  logic          r_hit_pend;
  logic          r_dx;          // 1 = moving right, 0 = moving left
  logic          r_dy;          // 1 = moving down,  0 = moving up
  logic          w_dx_bnc, w_dx_new, w_dy_new;
  logic [3:0]    r_control, w_ctrl_nxt, w_step_code;
  logic          r_active, r_shot, r_escaped;
  logic          w_wait_tick, w_step_take;

  assign control      = r_control;
  assign bird_active  = r_active;
  assign bird_shot    = r_shot;
  assign bird_escaped = r_escaped;

  assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_wait_tick = (r_state == S_WAIT) && w_tick;
  assign w_step_take = (r_state == S_CLEAR) && enable;

  // Free-running frame tick divider; never gated by the FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Edge bounce from the current position, evaluated for the CLEAR->STEP edge
  always_comb begin
    w_dx_bnc = r_dx;
    if (r_dx && (Xpos >= 8'(X_MAX)))  w_dx_bnc = 1'b0;
    else if (!r_dx && (Xpos == 8'd0)) w_dx_bnc = 1'b1;
    w_dy_new = r_dy;
    if (!r_dy && (Ypos == 7'd0))            w_dy_new = 1'b1;
    else if (r_dy && (Ypos >= 7'(Y_MAX)))   w_dy_new = 1'b0;
  end

`ifdef BIRD_RANDOM_TURN_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb, w_turn;

  // x^8 + x^6 + x^5 + x^4 + 1
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // LFSR advances once per frame tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_lfsr <= 8'hA5;
    else if (w_tick) r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  // A bounce this frame wins, and a turn never points the bird into a wall
  assign w_turn = (r_mode == M_FLY) && (r_lfsr[2:0] == 3'd0) &&
                  (w_dx_bnc == r_dx) &&
                  !(w_dx_bnc && (Xpos == 8'd0)) &&
                  !(!w_dx_bnc && (Xpos >= 8'(X_MAX)));
  assign w_dx_new = w_dx_bnc ^ w_turn;
`else
  assign w_dx_new = w_dx_bnc;
`endif

  // Step code from mode and the post-bounce direction
  always_comb begin
    w_step_code = C_HOLD;
    case (r_mode)
      M_SHOT:  w_step_code = C_SHOT;
      M_ESC:   w_step_code = C_ESCAPE;
      default: begin
        case ({w_dy_new, w_dx_new})
          2'b00:   w_step_code = C_UP_LEFT;
          2'b01:   w_step_code = C_UP_RIGHT;
          2'b10:   w_step_code = C_DOWN_LEFT;
          default: w_step_code = C_DOWN_RIGHT;
        endcase
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (go)     w_state_nxt = S_NEW;
      S_NEW:                w_state_nxt = S_DRAW;
      S_DRAW:   if (enable) w_state_nxt = S_WAIT;
      S_WAIT:   if (w_tick) w_state_nxt = S_CLEAR;
      S_CLEAR:  if (enable) w_state_nxt = S_STEP;
      S_STEP:               w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if ((r_mode != M_FLY) && !flying) w_state_nxt = S_DONE;
        else                              w_state_nxt = S_DRAW;
      end
      S_DONE:               w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  // Control code for the state being entered; registered below
  always_comb begin
    w_ctrl_nxt = C_HOLD;
    case (w_state_nxt)
      S_NEW:    w_ctrl_nxt = C_NEW;
      S_DRAW:   w_ctrl_nxt = C_DRAW;
      S_CLEAR:  w_ctrl_nxt = C_CLEAR;
      S_STEP:   w_ctrl_nxt = w_step_code;
      S_SETTLE: w_ctrl_nxt = C_PREHOLD;
      default:  w_ctrl_nxt = C_HOLD;
    endcase
  end

  // Registered outputs: control code, activity flag and one-cycle outcome pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_control <= C_HOLD;
      r_active  <= 1'b0;
      r_shot    <= 1'b0;
      r_escaped <= 1'b0;
    end else begin
      r_control <= w_ctrl_nxt;
      if (r_state == S_NEW)           r_active <= 1'b1;
      else if (w_state_nxt == S_DONE) r_active <= 1'b0;
      r_shot    <= (w_state_nxt == S_DONE) && (r_mode == M_SHOT);
      r_escaped <= (w_state_nxt == S_DONE) && (r_mode == M_ESC);
    end
  end

  // Flight bookkeeping: mode and frame count move on the WAIT tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode   <= M_FLY;
      r_frames <= 16'd0;
    end else if (r_state == S_NEW) begin
      r_mode   <= M_FLY;
      r_frames <= 16'd0;
    end else if (w_wait_tick && (r_mode == M_FLY)) begin
      if (r_hit_pend)                                  r_mode   <= M_SHOT;
      else if (r_frames == 16'(ESCAPE_FRAMES - 1))     r_mode   <= M_ESC;
      else                                             r_frames <= r_frames + 16'd1;
    end
  end

  // Shot latch: any state, but only for a live bird still in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       r_hit_pend <= 1'b0;
    else if (r_state == S_NEW)                          r_hit_pend <= 1'b0;
    else if (hit && r_active && (r_mode == M_FLY))      r_hit_pend <= 1'b1;
  end

  // Direction update on the CLEAR->STEP edge; persists across birds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dx <= 1'b1;
      r_dy <= 1'b0;
    end else if (w_step_take) begin
      r_dx <= w_dx_new;
      r_dy <= w_dy_new;
    end
  end

endmodule

// File: tb/tb_bird_control.sv
// tb_bird_control: randomized bench for bird_control with a frame-level
// reference model (direction, mode, frame count, pending shot).
module tb_bird_control;
  localparam int TICK_DIV = 40;
  localparam int EF       = 5;
  localparam int XM       = 157;
  localparam int YM       = 117;

  localparam logic [3:0] C_HOLD = 4'd0, C_CLEAR = 4'd1, C_UL = 4'd2, C_UR = 4'd3,
                         C_PRE = 4'd4, C_DRAW = 4'd5, C_DR = 4'd6, C_DL = 4'd7,
                         C_SHOT = 4'd8, C_ESC = 4'd9, C_NEW = 4'd10;

  logic       clk = 1'b0, reset_n = 1'b0, go = 1'b0, hit = 1'b0, enable = 1'b0, flying = 1'b0;
  logic [7:0] Xpos = 8'd80;
  logic [6:0] Ypos = 7'd60;
  logic [3:0] control;
  logic       bird_active, bird_shot, bird_escaped;

  int checks = 0, failures = 0;

  // model: direction persists across birds, the rest is per bird
  bit m_dx = 1'b1;   // 1 = right
  bit m_dy = 1'b0;   // 1 = down
  int m_mode = 0;    // 0 fly, 1 shot, 2 escape
  int m_frames = 0;
  bit m_hit = 1'b0;

  logic [7:0] xs [6];
  logic [6:0] ys [6];

  always #5 clk = ~clk;

  bird_control #(.TICK_DIV(TICK_DIV), .ESCAPE_FRAMES(EF), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .hit(hit), .enable(enable), .flying(flying),
    .Xpos(Xpos), .Ypos(Ypos), .control(control), .bird_active(bird_active),
    .bird_shot(bird_shot), .bird_escaped(bird_escaped));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // datapath stand-in: enable on the 16th cycle of a CLEAR or DRAW run
  int run_len = 0;
  logic [3:0] prev_ctrl = 4'd0;
  always @(negedge clk) begin : dp_model
    int n;
    if ((control == C_CLEAR || control == C_DRAW) && control == prev_ctrl) n = run_len + 1;
    else if (control == C_CLEAR || control == C_DRAW)                      n = 1;
    else                                                                   n = 0;
    run_len   <= n;
    prev_ctrl <= control;
    enable    <= (n == 16);
  end

  int shot_cnt = 0, esc_cnt = 0;
  always @(negedge clk) begin
    if (bird_shot)    shot_cnt <= shot_cnt + 1;
    if (bird_escaped) esc_cnt  <= esc_cnt + 1;
  end

  task automatic wait_ctrl(input logic [3:0] code, input int budget, input string tag, output bit ok);
    ok = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (control == code) return;
      @(negedge clk);
    end
    if (control != code) begin
      chk(tag, control, code);
      ok = 1'b0;
    end
  endtask

  // entered at a negedge with DRAW showing; optional hit/go on its first cycle
  task automatic draw_run(input bit do_hit, input bit do_go);
    int n = 1;
    hit = do_hit; go = do_go;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hit = 1'b0; go = 1'b0;
      if (control != C_DRAW) break;
      n++;
    end
    chk("draw_len", n, 16);
    chk("wait_code", control, C_HOLD);
  endtask

  function automatic logic [3:0] model_step();
    if (m_dx && Xpos >= XM)       m_dx = 1'b0;
    else if (!m_dx && Xpos == 0)  m_dx = 1'b1;
    if (!m_dy && Ypos == 0)       m_dy = 1'b1;
    else if (m_dy && Ypos >= YM)  m_dy = 1'b0;
    if (m_mode == 1) return C_SHOT;
    if (m_mode == 2) return C_ESC;
    if (m_dy) return m_dx ? C_DR : C_DL;
    return m_dx ? C_UR : C_UL;
  endfunction

  task automatic run_bird(input bit rnd, input logic [7:0] x0, input logic [6:0] y0,
                          input int hit_frame, input int fly_extra, input bit hit_late);
    int  s0, e0, n, extra;
    bit  ok, done;
    logic [3:0] exp;
    s0 = shot_cnt; e0 = esc_cnt; extra = 0; done = 1'b0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("new_code", control, C_NEW);
    chk("active_at_new", bird_active, 0);
    m_mode = 0; m_frames = 0; m_hit = 1'b0;
    @(negedge clk);
    chk("first_draw", control, C_DRAW);
    chk("active_after_new", bird_active, 1);
    draw_run(1'b0, 1'b0);
    for (int frame = 0; frame < 20 && !done; frame++) begin
      // frame tick decision
      if (m_mode == 0) begin
        if (m_hit)                 m_mode = 1;
        else if (m_frames == EF-1) m_mode = 2;
        else                       m_frames++;
      end
      wait_ctrl(C_CLEAR, 60, "wait_clear", ok);
      if (!ok) break;
      if (rnd) begin
        Xpos = xs[$urandom_range(0, 5)];
        Ypos = ys[$urandom_range(0, 5)];
      end else begin
        Xpos = x0; Ypos = y0;
      end
      n = 1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (control != C_CLEAR) break;
        n++;
      end
      chk("clear_len", n, 16);
      exp = model_step();
      chk("step_code", control, exp);
      @(negedge clk);
      chk("prehold", control, C_PRE);
      if (m_mode == 0) flying = 1'($urandom_range(0, 1));
      else begin
        flying = (extra < fly_extra);
        extra++;
      end
      @(negedge clk);
      if (m_mode != 0 && !flying) begin
        chk("done_code", control, C_HOLD);
        chk("done_shot", bird_shot, (m_mode == 1) ? 1 : 0);
        chk("done_esc", bird_escaped, (m_mode == 2) ? 1 : 0);
        chk("done_active", bird_active, 0);
        @(negedge clk);
        chk("shot_pulse_end", bird_shot, 0);
        chk("esc_pulse_end", bird_escaped, 0);
        chk("idle_code", control, C_HOLD);
        done = 1'b1;
      end else begin
        chk("redraw", control, C_DRAW);
        if (m_mode == 0 && frame == hit_frame) m_hit = 1'b1;
        draw_run((m_mode == 0 && frame == hit_frame) || (m_mode != 0 && hit_late),
                 1'($urandom_range(0, 1)));
      end
    end
    flying = 1'b0;
    chk("bird_finished", done, 1);
    repeat (2) @(negedge clk);
    chk("shot_count", shot_cnt - s0, (done && m_mode == 1) ? 1 : 0);
    chk("esc_count", esc_cnt - e0, (done && m_mode == 2) ? 1 : 0);
  endtask

  initial begin
    bit ok;
    int h;
    xs[0] = 8'd0;   xs[1] = 8'd1;   xs[2] = 8'd80;  xs[3] = 8'd156; xs[4] = 8'd157; xs[5] = 8'd158;
    ys[0] = 7'd0;   ys[1] = 7'd1;   ys[2] = 7'd60;  ys[3] = 7'd116; ys[4] = 7'd117; ys[5] = 7'd119;

    repeat (3) @(negedge clk);
    chk("rst_control", control, C_HOLD);
    chk("rst_active", bird_active, 0);
    chk("rst_shot", bird_shot, 0);
    chk("rst_esc", bird_escaped, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", control, C_HOLD);

    // free flight to escape, flying held for two extra frames, hit ignored in escape
    run_bird(1'b0, 8'd80, 7'd60, -1, 2, 1'b1);
    // shot during DRAW of frame 2
    run_bird(1'b0, 8'd80, 7'd60, 2, 0, 1'b0);
    // right-edge bounce, then top-edge bounce
    run_bird(1'b0, 8'd157, 7'd60, -1, 0, 1'b0);
    run_bird(1'b0, 8'd80, 7'd0, 1, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      h = $urandom_range(0, 6);
      if (h == 6) h = -1;
      run_bird(1'b1, 8'd0, 7'd0, h, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of CLEAR
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    Xpos = 8'd157; Ypos = 7'd0;
    wait_ctrl(C_CLEAR, 80, "pre_reset_clear", ok);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_control", control, C_HOLD);
    chk("async_active", bird_active, 0);
    chk("async_shot", bird_shot, 0);
    chk("async_esc", bird_escaped, 0);
    @(negedge clk); reset_n = 1'b1;
    m_dx = 1'b1; m_dy = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_reset_idle", control, C_HOLD);
    run_bird(1'b0, 8'd80, 7'd60, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

endmodule
